sensor_emulator: RTL and testbench
==================================

SENSOR_EMULATOR -- requirements
Module: sensor_emulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period registers and period counters.
REQ-002 SHALL have parameter PW_W, default 8: width of the pulse-width register and pulse counter.
REQ-003 SHALL have port HCLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have AHB-Lite slave inputs HSEL 1, HREADY 1, HWRITE 1, HADDR 32 (only [3:2] decoded), HWDATA 32, HSIZE 3 (ignored; word access only), HTRANS 2.
REQ-006 SHALL have outputs HRDATA 32 and HREADYOUT 1.
REQ-007 SHALL have outputs nFork 1 and nCrank 1: emulated active-low sensor pulses, idle high.

Function
REQ-008 SHALL capture address phase when HSEL && HREADY && HTRANS[1]; SHALL act in the following data phase; HREADYOUT SHALL be constant 1 (zero wait states).
REQ-009 SHALL map registers: 0x0 FORK_PERIOD[CNT_W-1:0] RW; 0x4 CRANK_PERIOD[CNT_W-1:0] RW; 0x8 PULSE_WIDTH[PW_W-1:0] RW; 0xC CTRL/STATUS.
REQ-010 CTRL write SHALL set bit0 fork_en and bit1 crank_en, and SHALL clear both pulse counts.
REQ-011 STATUS read SHALL return {crank_count[7:0], fork_count[7:0], 12'b0, crank_active, fork_active, crank_en, fork_en}; *_active = channel not OFF.
REQ-012 Register writes SHALL take HWDATA at the clock edge ending the data phase; unused upper bits SHALL be discarded and read back 0.
REQ-013 HRDATA SHALL be driven combinationally during a read data phase and SHALL be 0 otherwise.
REQ-014 Each channel SHALL run an independent FSM with states OFF, LOW, HIGH.
REQ-015 At each entry to LOW, P and W SHALL be loaded into shadow registers; mid-period register writes SHALL take effect only at the next LOW entry.
REQ-016 Transitions: OFF->LOW when en=1 and P>=2; LOW->HIGH after W' cycles; HIGH->LOW after P-W' cycles if en=1 and P>=2, else HIGH->OFF.
REQ-017 Effective width SHALL be W' = W clamped to the range 1..P-1; falling edge to falling edge SHALL be exactly P cycles.
REQ-018 Output n* SHALL be 0 in LOW and 1 in OFF and HIGH, and SHALL be driven from a register.
REQ-019 First LOW cycle SHALL be the cycle immediately after the edge at which en becomes 1.
REQ-020 Clearing en during LOW SHALL NOT truncate the pulse: LOW completes, then HIGH runs its full remaining count, then OFF.
REQ-021 P<2 in the programmed register SHALL keep or return the channel to OFF at the next LOW-entry decision point.
REQ-022 An 8-bit pulse count per channel SHALL increment on each LOW entry and wrap 255->0.
REQ-023 When a CTRL write and a LOW entry occur on the same edge, the clear SHALL win: count reads 0.
REQ-024 fork and crank channels SHALL be fully independent; simultaneous pulses are permitted.

Reset
REQ-025 HRESET=1 at a rising edge SHALL clear all registers, counters and counts to 0, put both FSMs in OFF, and drive nFork=nCrank=1, HRDATA=0, HREADYOUT=1.
REQ-026 Reset asserted mid-pulse SHALL force n* high at that edge with no further pulse until re-enabled.

Verification
REQ-027 FORK_PERIOD=10, PULSE_WIDTH=3, CTRL=1 -> nFork low 3 cycles, high 7 cycles, repeating; first low cycle follows the CTRL write edge.
REQ-028 PULSE_WIDTH=20, CRANK_PERIOD=5, CTRL=2 -> nCrank low 4 cycles, high 1 cycle; after 300 pulses, STATUS[31:24]=44 (300 mod 256).
REQ-029 Running FORK_PERIOD=10; write 6 mid-period -> current period stays 10 cycles; next period is 6 cycles.
REQ-030 CTRL=0 written during LOW -> pulse completes at full width, trailing high completes, fork_active=0 afterwards, nFork stays 1.
REQ-031 Both channels enabled with equal P=8, W=2 -> coincident pulses on both outputs; STATUS reads {counts, 0, 1,1,1,1}; HRESET mid-pulse -> both outputs 1 next cycle and STATUS=0.
REQ-032 Idle transfer (HTRANS=00) with HSEL=1 and HWRITE=1 -> no register change and HRDATA=0; FORK_PERIOD=1 with CTRL=1 -> nFork stays 1 and fork_active=0.

Source files
------------

// File: rtl/sensor_emulator.sv
// AHB-Lite programmable emulator of the active-low fork and crank sensor pulse trains.
// Each channel runs its own OFF/LOW/HIGH sequencer with period and width shadowed at every falling edge.
module sensor_emulator #(
    parameter int CNT_W = 16,
    parameter int PW_W  = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        nFork,
    output logic        nCrank
);
    localparam int XW = CNT_W + PW_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    logic             dph_wr_r;
    logic             dph_rd_r;
    logic [1:0]       dph_addr_r;
    logic [CNT_W-1:0] per_r    [2];
    logic [CNT_W-1:0] per_nx_s [2];
    logic [PW_W-1:0]  pw_r;
    logic [PW_W-1:0]  pw_nx_s;
    logic [1:0]       en_r;
    logic [1:0]       en_nx_s;
    logic             ctrl_wr_s;
    logic [1:0]       n_s;
    logic [1:0]       active_s;
    logic [7:0]       count_s  [2];
    logic [31:0]      rdata_s;
    logic             unused_s;

    assign unused_s = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:CNT_W]};

    // Register values as they will stand after this edge; the sequencers decide on these
    always_comb begin
        per_nx_s[0] = per_r[0];
        per_nx_s[1] = per_r[1];
        pw_nx_s     = pw_r;
        en_nx_s     = en_r;
        ctrl_wr_s   = 1'b0;
        if (dph_wr_r) begin
            case (dph_addr_r)
                2'd0: per_nx_s[0] = HWDATA[CNT_W-1:0];
                2'd1: per_nx_s[1] = HWDATA[CNT_W-1:0];
                2'd2: pw_nx_s     = HWDATA[PW_W-1:0];
                2'd3: begin
                    en_nx_s   = HWDATA[1:0];
                    ctrl_wr_s = 1'b1;
                end
                default: ctrl_wr_s = 1'b0;
            endcase
        end else begin
            ctrl_wr_s = 1'b0;
        end
    end

    // Bus address-phase capture and programmable registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dph_wr_r   <= 1'b0;
            dph_rd_r   <= 1'b0;
            dph_addr_r <= 2'd0;
            per_r[0]   <= CNT_ZERO;
            per_r[1]   <= CNT_ZERO;
            pw_r       <= {PW_W{1'b0}};
            en_r       <= 2'b00;
        end else begin
            if (HREADY) begin
                dph_wr_r   <= HSEL && HTRANS[1] && HWRITE;
                dph_rd_r   <= HSEL && HTRANS[1] && !HWRITE;
                dph_addr_r <= HADDR[3:2];
            end
            per_r[0] <= per_nx_s[0];
            per_r[1] <= per_nx_s[1];
            pw_r     <= pw_nx_s;
            en_r     <= en_nx_s;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t           state_r;
        state_t           state_nx_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] per_sh_r;
        logic [CNT_W-1:0] wid_sh_r;
        logic [CNT_W-1:0] wid_eff_s;
        logic [XW-1:0]    per_x_s;
        logic [XW-1:0]    pw_x_s;
        logic             restart_s;
        logic             start_s;
        logic             n_r;
        logic             n_nx_s;
        logic [7:0]       count_r;

        assign restart_s = en_nx_s[c] && (per_nx_s[c] >= CNT_TWO);

        // Programmed width clamped to 1..P-1 so both phases last at least one cycle
        always_comb begin
            per_x_s = XW'(per_nx_s[c]);
            pw_x_s  = XW'(pw_nx_s);
            if (pw_x_s == {XW{1'b0}}) begin
                wid_eff_s = CNT_ONE;
            end else if (pw_x_s >= per_x_s) begin
                wid_eff_s = per_nx_s[c] - CNT_ONE;
            end else begin
                wid_eff_s = pw_x_s[CNT_W-1:0];
            end
        end

        // Next-state decision
        always_comb begin
            state_nx_s = state_r;
            case (state_r)
                ST_OFF: begin
                    if (restart_s) state_nx_s = ST_LOW;
                    else           state_nx_s = ST_OFF;
                end
                ST_LOW: begin
                    if (cnt_r == CNT_ZERO) state_nx_s = ST_HIGH;
                    else                   state_nx_s = ST_LOW;
                end
                ST_HIGH: begin
                    if (cnt_r != CNT_ZERO) state_nx_s = ST_HIGH;
                    else if (restart_s)    state_nx_s = ST_LOW;
                    else                   state_nx_s = ST_OFF;
                end
                default: state_nx_s = ST_OFF;
            endcase
        end

        // LOW entry strobe and next pulse level
        always_comb begin
            start_s = (state_nx_s == ST_LOW) && (state_r != ST_LOW);
            n_nx_s  = (state_nx_s == ST_LOW) ? 1'b0 : 1'b1;
        end

        // State register with registered pulse output
        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                state_r <= ST_OFF;
                n_r     <= 1'b1;
            end else begin
                state_r <= state_nx_s;
                n_r     <= n_nx_s;
            end
        end

        // Phase down-counter, shadow registers and pulse count (a CTRL write clear beats an increment)
        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                cnt_r    <= CNT_ZERO;
                per_sh_r <= CNT_ZERO;
                wid_sh_r <= CNT_ZERO;
                count_r  <= 8'd0;
            end else begin
                if (start_s) begin
                    cnt_r    <= wid_eff_s - CNT_ONE;
                    per_sh_r <= per_nx_s[c];
                    wid_sh_r <= wid_eff_s;
                end else if ((state_r == ST_LOW) && (cnt_r == CNT_ZERO)) begin
                    cnt_r <= per_sh_r - wid_sh_r - CNT_ONE;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_r <= cnt_r - CNT_ONE;
                end else begin
                    cnt_r <= cnt_r;
                end
                if (ctrl_wr_s)    count_r <= 8'd0;
                else if (start_s) count_r <= count_r + 8'd1;
                else              count_r <= count_r;
            end
        end

        assign n_s[c]      = n_r;
        assign active_s[c] = (state_r != ST_OFF);
        assign count_s[c]  = count_r;
    end

    // Read data is only driven during a read data phase
    always_comb begin
        rdata_s = 32'd0;
        if (dph_rd_r) begin
            case (dph_addr_r)
                2'd0: rdata_s = 32'(per_r[0]);
                2'd1: rdata_s = 32'(per_r[1]);
                2'd2: rdata_s = 32'(pw_r);
                2'd3: rdata_s = {count_s[1], count_s[0], 12'd0,
                                 active_s[1], active_s[0], en_r[1], en_r[0]};
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign HRDATA    = rdata_s;
    assign HREADYOUT = 1'b1;
    assign nFork     = n_s[0];
    assign nCrank    = n_s[1];

endmodule

// File: tb/tb_sensor_emulator.sv
// Directed bench for sensor_emulator: a pulse-timeline model checked every cycle plus literal spot checks.
module tb_sensor_emulator;
    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL   = 1'b0;
    logic        HREADY = 1'b1;
    logic        HWRITE = 1'b0;
    logic [31:0] HADDR  = 32'd0;
    logic [31:0] HWDATA = 32'd0;
    logic [2:0]  HSIZE  = 3'b010;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        nFork;
    logic        nCrank;

    int total = 0;
    int bad   = 0;

    sensor_emulator dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .nFork(nFork), .nCrank(nCrank)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Model: registers plus, per channel, the start cycle, period and width of the pulse in progress
    int m_per[2];
    int m_pw;
    int m_cnt[2];
    bit m_en[2];
    bit act[2];
    int t0[2];
    int cper[2];
    int cwid[2];
    bit ph_wr;
    bit ph_rd;
    int ph_addr;
    int cyc;
    bit exp_n[2];
    logic [31:0] exp_rd;

    function automatic int eff_width(input int p, input int w);
        if (w == 0) return 1;
        if (w >= p) return p - 1;
        return w;
    endfunction

    initial begin : model
        bit ctrl_wr;
        cyc = 0; m_pw = 0; ph_wr = 0; ph_rd = 0; ph_addr = 0;
        for (int c = 0; c < 2; c++) begin
            m_per[c] = 0; m_cnt[c] = 0; m_en[c] = 0; act[c] = 0; t0[c] = 0; cper[c] = 0; cwid[c] = 0;
        end
        forever begin
            @(posedge HCLK);
            cyc++;
            if (HRESET) begin
                m_pw = 0; ph_wr = 0; ph_rd = 0; ph_addr = 0;
                for (int c = 0; c < 2; c++) begin
                    m_per[c] = 0; m_cnt[c] = 0; m_en[c] = 0; act[c] = 0;
                end
            end else begin
                ctrl_wr = 0;
                if (ph_wr) begin
                    case (ph_addr)
                        0: m_per[0] = int'(HWDATA[15:0]);
                        1: m_per[1] = int'(HWDATA[15:0]);
                        2: m_pw     = int'(HWDATA[7:0]);
                        default: begin
                            m_en[0] = HWDATA[0];
                            m_en[1] = HWDATA[1];
                            ctrl_wr = 1;
                        end
                    endcase
                end
                ph_wr   = HSEL && HREADY && HTRANS[1] && HWRITE;
                ph_rd   = HSEL && HREADY && HTRANS[1] && !HWRITE;
                ph_addr = int'(HADDR[3:2]);
                for (int c = 0; c < 2; c++) begin
                    if (act[c] && (cyc - t0[c]) < cper[c]) begin
                        act[c] = 1;
                    end else if (m_en[c] && m_per[c] >= 2) begin
                        act[c]   = 1;
                        t0[c]    = cyc;
                        cper[c]  = m_per[c];
                        cwid[c]  = eff_width(m_per[c], m_pw);
                        m_cnt[c] = (m_cnt[c] + 1) % 256;
                    end else begin
                        act[c] = 0;
                    end
                    if (ctrl_wr) m_cnt[c] = 0;
                end
            end
            for (int c = 0; c < 2; c++) exp_n[c] = !(act[c] && (cyc - t0[c]) < cwid[c]);
            if (!ph_rd)            exp_rd = 32'd0;
            else if (ph_addr == 0) exp_rd = 32'(m_per[0]);
            else if (ph_addr == 1) exp_rd = 32'(m_per[1]);
            else if (ph_addr == 2) exp_rd = 32'(m_pw);
            else exp_rd = {8'(m_cnt[1]), 8'(m_cnt[0]), 12'd0, act[1], act[0], m_en[1], m_en[0]};
            @(negedge HCLK);
            chk("model_nFork", nFork, exp_n[0]);
            chk("model_nCrank", nCrank, exp_n[1]);
            chk("model_HRDATA", HRDATA, exp_rd);
            chk("model_HREADYOUT", HREADYOUT, 1'b1);
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic wait_fall(input bit crank, output bit found);
        logic prev;
        logic now;
        prev  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge HCLK);
            now = crank ? nCrank : nFork;
            if (prev && !now) found = 1'b1;
            prev = now;
        end
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic [29:0] v30;
        logic [15:0] vf;
        logic [15:0] vc;
        logic [9:0]  v10;
        logic        prev;
        logic        now;
        bit          found;
        int          t;
        int          nf;
        int          falls[3];

        falls[0] = 0; falls[1] = 0; falls[2] = 0;
        repeat (3) @(negedge HCLK);
        chk("reset_nFork", nFork, 1'b1);
        chk("reset_nCrank", nCrank, 1'b1);
        chk("reset_HRDATA", HRDATA, 32'd0);
        chk("reset_HREADYOUT", HREADYOUT, 1'b1);
        HRESET = 1'b0;
        bus_read(32'hC, rd);
        chk("status_after_reset", rd, 32'd0);

        // P=10, W=3 (upper width bits written and discarded)
        bus_write(32'h0, 32'd10);
        bus_write(32'h8, 32'h0000_0103);
        bus_read(32'h8, rd);
        chk("pw_readback", rd, 32'd3);
        bus_read(32'h0, rd);
        chk("fork_period_readback", rd, 32'd10);
        bus_write(32'hC, 32'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge HCLK);
            v30[i] = nFork;
        end
        chk("fork_p10_w3_pattern", v30, 30'b1111111000_1111111000_1111111000);

        // Period rewritten mid-period: current stays 10, following ones are 6
        wait_fall(1'b0, found);
        chk("sync_fall_period", found, 1'b1);
        bus_write(32'h0, 32'd6);
        prev = nFork; t = 2; nf = 0;
        while (nf < 3 && t < 60) begin
            @(negedge HCLK);
            t++;
            now = nFork;
            if (prev && !now) begin
                falls[nf] = t;
                nf++;
            end
            prev = now;
        end
        chk("falls_found", nf, 32'd3);
        chk("fall_1_at_10", falls[0], 32'd10);
        chk("fall_2_at_16", falls[1], 32'd16);
        chk("fall_3_at_22", falls[2], 32'd22);

        // Disable during LOW with W=4, P=6: pulse and trailing high finish, then idle
        bus_write(32'h8, 32'd4);
        wait_fall(1'b0, found);
        chk("sync_fall_disable", found, 1'b1);
        bus_write(32'hC, 32'd0);
        chk("low_kept_after_disable", nFork, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            v10[i] = nFork;
        end
        chk("disable_tail_pattern", v10, 10'b1111111110);
        bus_read(32'hC, rd);
        chk("status_after_disable", rd, 32'd0);

        // W=20 clamps to 4 with P=5; 300 pulses after the enabling one wrap the count to 44
        bus_write(32'h8, 32'd20);
        bus_write(32'h4, 32'd5);
        bus_write(32'hC, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            v10[i] = nCrank;
        end
        chk("crank_clamp_pattern", v10, 10'b1000010000);
        repeat (1491) @(negedge HCLK);
        bus_read(32'hC, rd);
        chk("crank_count_wrap", rd[31:24], 8'd44);
        chk("status_crank_only", rd, 32'h2C00_000A);

        // Both channels P=8, W=2, enabled together
        bus_write(32'h0, 32'd8);
        bus_write(32'h4, 32'd8);
        bus_write(32'h8, 32'd2);
        bus_write(32'hC, 32'd0);
        repeat (20) @(negedge HCLK);
        bus_write(32'hC, 32'd3);
        for (int i = 0; i < 16; i++) begin
            @(negedge HCLK);
            vf[i] = nFork;
            vc[i] = nCrank;
        end
        chk("both_fork_pattern", vf, 16'b1111110011111100);
        chk("both_crank_pattern", vc, 16'b1111110011111100);
        bus_read(32'hC, rd);
        chk("status_both", rd, 32'h0202_000F);
        repeat (7) @(negedge HCLK);
        chk("both_low_before_reset", {nFork, nCrank}, 2'b00);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("reset_mid_pulse", {nFork, nCrank}, 2'b11);
        HRESET = 1'b0;
        bus_read(32'hC, rd);
        chk("status_after_mid_reset", rd, 32'd0);

        // Idle transfer with HSEL and HWRITE set must not write
        @(negedge HCLK);
        HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b00; HADDR = 32'h0;
        @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'h55;
        @(negedge HCLK);
        chk("idle_no_rdata", HRDATA, 32'd0);
        bus_read(32'h0, rd);
        chk("idle_no_write", rd, 32'd0);

        // P=1 never starts; then P=4 with W=0 gives a one-cycle pulse
        bus_write(32'h0, 32'd1);
        bus_write(32'hC, 32'd1);
        repeat (10) @(negedge HCLK);
        chk("p1_stays_high", nFork, 1'b1);
        bus_read(32'hC, rd);
        chk("p1_status", rd, 32'd1);
        bus_write(32'h0, 32'd4);
        repeat (12) @(negedge HCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
